// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//   Round-robin arbiter and command sequencer sharing one I2C master between
//   NUM_REQ requesters. Grants one requester, writes its control word to the
//   master, follows the master busy flag (status[31]) to completion and
//   returns the final status word with a one-cycle ack.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   MAX_RETRY  reissues after an address NACK (only with I2C_ARB_RETRY_EN)
//
// Ports
//   sys_clock   in   system clock (shared with the I2C master)
//   reset       in   synchronous active-high reset
//   req         in   per-requester request level
//   req_ctrl    in   control words, requester i at [32*i+31:32*i]
//   gnt         out  one-hot grant, high from grant until ack
//   ack         out  one-cycle completion pulse to the granted requester
//   rsp_status  out  master status captured at completion (held after ack)
//   rsp_err     out  address/data NACK, overrun, or accept timeout
//   ctrl_data   out  to master ctrl_data
//   wr_ctrl     out  to master wr_ctrl, one-cycle pulse
//   status      in   from master status
//
// Build option
//   I2C_ARB_RETRY_EN  when defined, an address NACK is reissued up to
//                     MAX_RETRY times before responding with an error.
module i2c_master_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                   sys_clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_ctrl,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic [31:0]            rsp_status,
  output logic                   rsp_err,
  output logic [31:0]            ctrl_data,
  output logic                   wr_ctrl,
  input  logic [31:0]            status
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    IDLE        = 3'd1,
    ISSUE       = 3'd2,
    WAIT_ACCEPT = 3'd3,
    WAIT_DONE   = 3'd4,
    RESPOND     = 3'd5
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        gnt_idx_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [NUM_REQ-1:0]   ack_r;
  logic [31:0]          ctrl_data_r;
  logic                 wr_ctrl_r;
  logic [31:0]          rsp_status_r;
  logic                 rsp_err_r;
  logic [31:0]          cap_status_r;
  logic                 cap_err_r;
  logic [2:0]           acc_cnt_r;

  logic                 found_s;
  logic [IW-1:0]        sel_s;
  logic [IW-1:0]        cand_s;
  logic                 grant_s;
  logic                 pulse_s;
  logic                 timeout_s;
  logic                 done_s;
  logic                 respond_s;

`ifdef I2C_ARB_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0]        retry_cnt_r;
  logic                 retry_s;
`endif

  // Index wrap-around modulo NUM_REQ for values in 0 .. 2*NUM_REQ-1.
  function automatic logic [IW-1:0] wrap_idx(input int v);
    if (v >= NUM_REQ) begin
      wrap_idx = IW'(v - NUM_REQ);
    end else begin
      wrap_idx = IW'(v);
    end
  endfunction

  // Round-robin pick: scanned from the far end so the smallest offset from ptr wins.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    cand_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s  = wrap_idx(int'(ptr_r) + k);
      sel_s   = req[cand_s] ? cand_s : sel_s;
      found_s = found_s | req[cand_s];
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_r <= INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and one-cycle action strobes.
  always_comb begin
    state_s   = state_r;
    grant_s   = 1'b0;
    pulse_s   = 1'b0;
    timeout_s = 1'b0;
    done_s    = 1'b0;
    respond_s = 1'b0;
`ifdef I2C_ARB_RETRY_EN
    retry_s   = 1'b0;
`endif
    case (state_r)
      INIT: begin
        if (!status[31]) state_s = IDLE;
        else             state_s = INIT;
      end
      IDLE: begin
        if (!status[31] && found_s) begin
          grant_s = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // Never write the control register while the master still reads busy.
        if (!status[31]) begin
          pulse_s = 1'b1;
          state_s = WAIT_ACCEPT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_ACCEPT: begin
        if (status[31]) begin
          state_s = WAIT_DONE;
        end else if (acc_cnt_r == 3'd3) begin
          timeout_s = 1'b1;
          state_s   = RESPOND;
        end else begin
          state_s = WAIT_ACCEPT;
        end
      end
      WAIT_DONE: begin
        if (!status[31]) begin
`ifdef I2C_ARB_RETRY_EN
          if (status[30] && (retry_cnt_r < RW'(MAX_RETRY))) begin
            retry_s = 1'b1;
            state_s = ISSUE;
          end else begin
            done_s  = 1'b1;
            state_s = RESPOND;
          end
`else
          done_s  = 1'b1;
          state_s = RESPOND;
`endif
        end else begin
          state_s = WAIT_DONE;
        end
      end
      RESPOND: begin
        respond_s = 1'b1;
        state_s   = IDLE;
      end
      default: begin
        state_s = INIT;
      end
    endcase
  end

  // Datapath: grant, command word, accept timer, status capture and response.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      gnt_r        <= '0;
      ack_r        <= '0;
      ptr_r        <= '0;
      gnt_idx_r    <= '0;
      ctrl_data_r  <= 32'h0000_0000;
      wr_ctrl_r    <= 1'b0;
      rsp_status_r <= 32'h0000_0000;
      rsp_err_r    <= 1'b0;
      cap_status_r <= 32'h0000_0000;
      cap_err_r    <= 1'b0;
      acc_cnt_r    <= 3'd0;
    end else begin
      wr_ctrl_r <= pulse_s;
      ack_r     <= '0;
      if (grant_s) begin
        gnt_r       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_s;
        gnt_idx_r   <= sel_s;
        ctrl_data_r <= req_ctrl[32*int'(sel_s) +: 32];
      end
      if (pulse_s) begin
        acc_cnt_r <= 3'd0;
      end else if (state_r == WAIT_ACCEPT) begin
        acc_cnt_r <= acc_cnt_r + 3'd1;
      end
      if (timeout_s) begin
        cap_status_r <= status;
        cap_err_r    <= 1'b1;
      end
      if (done_s) begin
        cap_status_r <= status;
        cap_err_r    <= status[30] | status[29] | status[27];
      end
      if (respond_s) begin
        ack_r        <= gnt_r;
        gnt_r        <= '0;
        rsp_status_r <= cap_status_r;
        rsp_err_r    <= cap_err_r;
        ptr_r        <= wrap_idx(int'(gnt_idx_r) + 1);
      end
    end
  end

`ifdef I2C_ARB_RETRY_EN
  // Address-NACK retry count, cleared on every new grant.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      retry_cnt_r <= '0;
    end else if (grant_s) begin
      retry_cnt_r <= '0;
    end else if (retry_s) begin
      retry_cnt_r <= retry_cnt_r + RW'(1);
    end
  end
`endif

  assign gnt        = gnt_r;
  assign ack        = ack_r;
  assign rsp_status = rsp_status_r;
  assign rsp_err    = rsp_err_r;
  assign ctrl_data  = ctrl_data_r;
  assign wr_ctrl    = wr_ctrl_r;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Testbench for i2c_master_arbiter: behavioural I2C master model, table of
// directed transactions, plus hand-written reset and round-robin sequences.
module tb_i2c_master_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_RETRY = 3;
`ifdef I2C_ARB_RETRY_EN
  localparam int NACK_WR = MAX_RETRY + 1;
`else
  localparam int NACK_WR = 1;
`endif

  logic                  sys_clock = 1'b0;
  logic                  reset     = 1'b1;
  logic [NUM_REQ-1:0]    req       = 4'b0000;
  logic [32*NUM_REQ-1:0] req_ctrl;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           rsp_status;
  logic                  rsp_err;
  logic [31:0]           ctrl_data;
  logic                  wr_ctrl;
  logic [31:0]           status;

  // master model controls (written only by the stimulus process)
  logic        m_hold   = 1'b1;
  logic [31:0] m_forced = 32'h8400_0000;
  int          m_mode   = 0;          // 0: normal, 1: never goes busy
  int          m_len    = 5;          // busy cycles per transaction
  logic [31:0] m_done   = 32'h0000_0000;
  logic [31:0] m_status_r;
  int          m_cnt;

  int total = 0;
  int bad   = 0;
  int onehot_bad = 0;

  i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .MAX_RETRY(MAX_RETRY)) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .req       (req),
    .req_ctrl  (req_ctrl),
    .gnt       (gnt),
    .ack       (ack),
    .rsp_status(rsp_status),
    .rsp_err   (rsp_err),
    .ctrl_data (ctrl_data),
    .wr_ctrl   (wr_ctrl),
    .status    (status)
  );

  always #5 sys_clock = ~sys_clock;

  assign status = m_hold ? m_forced : m_status_r;

  // Master model: busy for m_len cycles after a wr_ctrl, then shows m_done.
  always @(posedge sys_clock) begin
    if (reset) begin
      m_status_r <= 32'h0000_0000;
      m_cnt      <= 0;
    end else if (wr_ctrl && m_mode == 0) begin
      m_status_r <= 32'h8000_0000;
      m_cnt      <= m_len;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt      <= 0;
      m_status_r <= m_done;
    end
  end

  // Grant must never have more than one bit set.
  always @(negedge sys_clock) begin
    if ($countones(gnt) > 1) onehot_bad <= onehot_bad + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0010 + 32'(i) * 32'h0000_0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Waits (bounded) for an ack, counting wr_ctrl pulses and latency wr->ack.
  task automatic run_until_ack(input int limit, output logic got,
                               output logic [NUM_REQ-1:0] ack_v, output logic [31:0] st,
                               output logic er, output int nwr, output int lat,
                               output logic [31:0] wr_data);
    int wr_at;
    got = 1'b0; ack_v = '0; st = 32'h0; er = 1'b0; nwr = 0; lat = 0;
    wr_data = 32'h0; wr_at = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge sys_clock);
      if (wr_ctrl) begin
        nwr++;
        wr_at   = k;
        wr_data = ctrl_data;
      end
      if (|ack) begin
        got   = 1'b1;
        ack_v = ack;
        st    = rsp_status;
        er    = rsp_err;
        lat   = k - wr_at;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    int          mode;
    int          len;
    logic [31:0] done;
    int          exp_idx;
    logic [31:0] exp_status;
    logic        chk_status;
    logic        exp_err;
    int          exp_wr;
    int          exp_lat;   // 0: not checked
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic              got;
    logic [3:0]        ack_v;
    logic [3:0]        exp_mask;
    logic [31:0]       st;
    logic [31:0]       wr_data;
    logic              er;
    int                nwr;
    int                lat;
    int                cnt_w;
    int                cnt_g;
    int                rr_exp[5];

    for (int i = 0; i < NUM_REQ; i++) req_ctrl[32*i +: 32] = word(i);

    //            req      mode len done           idx status         chk err wr       lat
    vecs[0] = '{4'b0001, 0,   6, 32'h1000_00A5, 0, 32'h1000_00A5, 1'b1, 1'b0, 1,      9};
    vecs[1] = '{4'b0110, 0,   3, 32'h0000_0011, 1, 32'h0000_0011, 1'b1, 1'b0, 1,      6};
    vecs[2] = '{4'b0110, 0,   4, 32'h2000_0000, 2, 32'h2000_0000, 1'b1, 1'b1, 1,      7};
    vecs[3] = '{4'b1001, 0,   2, 32'h0800_0000, 3, 32'h0800_0000, 1'b1, 1'b1, 1,      5};
    vecs[4] = '{4'b0100, 1,   2, 32'h0000_0000, 2, 32'h0000_0000, 1'b0, 1'b1, 1,      5};
    vecs[5] = '{4'b1111, 0,   2, 32'h0000_0000, 3, 32'h0000_0000, 1'b1, 1'b0, 1,      5};
    vecs[6] = '{4'b0001, 0,   3, 32'h4000_0000, 0, 32'h4000_0000, 1'b1, 1'b1, NACK_WR, 0};
    vecs[7] = '{4'b1000, 0,   1, 32'h0000_00FF, 3, 32'h0000_00FF, 1'b1, 1'b0, 1,      4};

    // ---- reset values, master busy/initialising after reset ----
    req      = 4'b0001;
    m_hold   = 1'b1;
    m_forced = 32'h8400_0000;
    repeat (3) @(negedge sys_clock);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rsp_status", rsp_status, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_ctrl_data", ctrl_data, 32'h0);
    check("rst_wr_ctrl", 32'(wr_ctrl), 32'h0);
    reset = 1'b0;
    cnt_w = 0; cnt_g = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clock);
      if (wr_ctrl) cnt_w++;
      if (|gnt) cnt_g++;
    end
    check("init_no_wr", 32'(cnt_w), 32'h0);
    check("init_no_gnt", 32'(cnt_g), 32'h0);
    m_hold = 1'b0;
    m_mode = 0; m_len = 4; m_done = 32'h0000_0000;
    run_until_ack(200, got, ack_v, st, er, nwr, lat, wr_data);
    req = 4'b0000;
    check("init_got_ack", 32'(got), 32'h1);
    check("init_ack", 32'(ack_v), 32'h1);
    check("init_wr_count", 32'(nwr), 32'h1);
    check("init_wr_data", wr_data, word(0));
    check("init_err", 32'(er), 32'h0);
    repeat (2) @(negedge sys_clock);

    // ---- directed transaction table (ptr now 1) ----
    for (int v = 0; v < 8; v++) begin
      m_mode = vecs[v].mode;
      m_len  = vecs[v].len;
      m_done = vecs[v].done;
      req    = vecs[v].req;
      exp_mask = 4'b0001 << vecs[v].exp_idx;
      run_until_ack(300, got, ack_v, st, er, nwr, lat, wr_data);
      req = 4'b0000;
      check($sformatf("v%0d_got_ack", v), 32'(got), 32'h1);
      check($sformatf("v%0d_ack", v), 32'(ack_v), 32'(exp_mask));
      if (vecs[v].chk_status) check($sformatf("v%0d_status", v), st, vecs[v].exp_status);
      check($sformatf("v%0d_err", v), 32'(er), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_wr_count", v), 32'(nwr), 32'(vecs[v].exp_wr));
      check($sformatf("v%0d_wr_data", v), wr_data, word(vecs[v].exp_idx));
      if (vecs[v].exp_lat != 0) check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      @(negedge sys_clock);
      check($sformatf("v%0d_ack_pulse", v), 32'(ack), 32'h0);
      check($sformatf("v%0d_ctrl_hold", v), ctrl_data, word(vecs[v].exp_idx));
      @(negedge sys_clock);
    end

    // ---- reset during WAIT_DONE (ptr now 0) ----
    m_mode = 0; m_len = 30; m_done = 32'h0000_0011;
    req = 4'b0010;
    cnt_w = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clock);
      if (wr_ctrl) begin
        cnt_w = 1;
        break;
      end
    end
    check("mid_wr_seen", 32'(cnt_w), 32'h1);
    repeat (5) @(negedge sys_clock);
    reset    = 1'b1;
    m_hold   = 1'b1;
    m_forced = 32'h8400_0000;
    @(negedge sys_clock);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_wr_ctrl", 32'(wr_ctrl), 32'h0);
    check("mid_rst_ctrl_data", ctrl_data, 32'h0);
    check("mid_rst_rsp_status", rsp_status, 32'h0);
    check("mid_rst_rsp_err", 32'(rsp_err), 32'h0);
    reset = 1'b0;
    cnt_w = 0; cnt_g = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clock);
      if (wr_ctrl) cnt_w++;
      if (|gnt) cnt_g++;
    end
    check("mid_busy_no_wr", 32'(cnt_w), 32'h0);
    check("mid_busy_no_gnt", 32'(cnt_g), 32'h0);
    m_hold = 1'b0;
    m_len  = 3;
    run_until_ack(200, got, ack_v, st, er, nwr, lat, wr_data);
    req = 4'b0000;
    check("mid_recover_ack", 32'(ack_v), 32'h2);
    check("mid_recover_status", st, 32'h0000_0011);
    repeat (2) @(negedge sys_clock);

    // ---- round robin with all requests held ----
    reset = 1'b1;
    repeat (2) @(negedge sys_clock);
    reset = 1'b0;
    m_mode = 0; m_len = 20; m_done = 32'h0000_0000;
    rr_exp = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_until_ack(200, got, ack_v, st, er, nwr, lat, wr_data);
      exp_mask = 4'b0001 << rr_exp[n];
      check($sformatf("rr%0d_ack", n), 32'(ack_v), 32'(exp_mask));
      check($sformatf("rr%0d_latency", n), 32'(lat), 32'd23);
    end
    req = 4'b0000;
    repeat (3) @(negedge sys_clock);
    check("gnt_onehot", 32'(onehot_bad), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and command sequencer that shares one `I2C_master` controller between `NUM_REQ` requesters. It grants one requester at a time and writes that requester's 32-bit control word to the master's control register. It then tracks the master's busy flag until the transaction completes and returns the final status word to the winning requester. It sits between the system-side register clients and the `ctrl_data`/`wr_ctrl`/`status` port of the I2C master.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_RETRY`, 3: reissues allowed after an address NACK. Used only when `I2C_ARB_RETRY_EN` is defined.
- `sys_clock`  in  1: system clock, same clock as the I2C master.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  NUM_REQ: per-requester request level.
- `req_ctrl`  in  32*NUM_REQ: control words; requester i uses bits [32*i+31:32*i]. Format matches the master control register.
- `gnt`  out  NUM_REQ: one-hot; high from grant until `ack`.
- `ack`  out  NUM_REQ: one-cycle completion pulse to the granted requester.
- `rsp_status`  out  32: master status captured at completion; valid while `ack` is high, held afterwards.
- `rsp_err`  out  1: valid with `ack`. Set if status[30] (address NACK), status[29] (data NACK) or status[27] (overrun) was set at completion, or on accept timeout.
- `ctrl_data`  out  32: to master `ctrl_data`.
- `wr_ctrl`  out  1: to master `wr_ctrl`; one-cycle pulse.
- `status`  in  32: from master `status`.

## Operation
- States: INIT, IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESPOND.
- INIT (entered on reset):
  - wait for status[31]=0; this covers the master's busy/initializing value 0x84000000.
  - then go to IDLE.
- IDLE, when status[31]=0 and any `req` bit is high:
  - select the first requester at or after pointer `ptr`, searching in increasing index order with wrap-around modulo NUM_REQ.
  - latch its `req_ctrl` word into `ctrl_data`, set its `gnt` bit, and go to ISSUE.
- ISSUE: drive `wr_ctrl`=1 for exactly one cycle, then go to WAIT_ACCEPT with the accept counter cleared.
- WAIT_ACCEPT:
  - status[31]=1 → WAIT_DONE.
  - 4 cycles without status[31]=1 → RESPOND with `rsp_err` forced to 1.
- WAIT_DONE: on status[31]=0, capture `status` and go to RESPOND.
- RESPOND:
  - pulse `ack`[granted] with `rsp_status`/`rsp_err`.
  - clear `gnt`, set `ptr` = granted index + 1 mod NUM_REQ, return to IDLE.
- `ctrl_data` is stable from ISSUE until the next grant.
- `wr_ctrl` is never asserted while the last sampled status[31]=1, so the master's overrun flag is never set by the arbiter.
- Dropping `req` after grant does not cancel the transaction; `ack` is still issued.
- Requests arriving while not in IDLE wait; no request is lost while `req` stays high.
- Requesters hold `req` until `ack`. Re-asserting `req` in the cycle after `ack` is allowed.

## Timing
- Reset values: `gnt`=0, `ack`=0, `rsp_status`=0, `rsp_err`=0, `ctrl_data`=0, `wr_ctrl`=0, `ptr`=0, state INIT, retry count 0.
- Reset mid-transaction: outputs return to reset values on the next edge. The arbiter then re-enters INIT and grants nothing until the master shows status[31]=0.
- Cycle-level sequence, starting from a request sampled at edge t in IDLE with status[31]=0:
  - `gnt` and `ctrl_data` valid after edge t.
  - `wr_ctrl` high for the cycle after edge t+1.
  - master busy is seen at t+2 or later.
  - `ack` is high for the single cycle after the edge that samples status[31]=0 in WAIT_DONE, plus one.
- Minimum arbiter overhead: 3 cycles per transaction, excluding master bus time.
- Two requests in the same cycle: `ptr` decides the winner; the other is served next.

## Configuration
- `I2C_ARB_RETRY_EN` defined:
  - in WAIT_DONE, if the captured status[30]=1 and retry count < MAX_RETRY, increment the count and return to ISSUE without pulsing `ack`; `gnt` stays held.
  - once retries are exhausted, respond normally with `rsp_err`=1.
  - the count clears on every grant.
- Not defined: no retry logic and no counter. Every completion goes straight to RESPOND; `MAX_RETRY` is ignored.

## Test plan
- Master model busy at reset (status=0x84000000) for 50 cycles, `req`=0001 from cycle 0 → no `wr_ctrl` before status[31]=0. Then exactly one `wr_ctrl` pulse with `ctrl_data`=`req_ctrl`[31:0].
- `req`=1111 held, master busy 20 cycles per transaction → `ack` order 0,1,2,3,0; exactly one `gnt` bit high at any time.
- Read transaction completing with status=0x100000A5 → `rsp_status`=0x100000A5, `rsp_err`=0, one-cycle `ack`.
- Master never raises busy after `wr_ctrl` → `ack` 5 cycles after `wr_ctrl`, `rsp_err`=1, next request served normally.
- Address NACK (status[30]=1) on every attempt, with `I2C_ARB_RETRY_EN` and MAX_RETRY=3 → 4 `wr_ctrl` pulses, then one `ack` with `rsp_err`=1. Without the macro → 1 pulse, then `ack`.
- `reset` asserted during WAIT_DONE → all outputs 0 next cycle; no grant until status[31]=0 is observed.
